// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side bus of the MEM-stage access unit.
// slave: the access unit itself; master: the controller/datapath plus RAM side.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        ld_mode;
    logic [2:0]        st_mode;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ld_mode, st_mode, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ld_mode, st_mode, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder for a word-wide synchronous single-port RAM.
// Byte/half stores use read-modify-write; loads are sign/zero extended.
// Optional: define MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses
// through rsp_err (otherwise rsp_err stays 0 and low address bits are ignored).
module mem_access_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    localparam int unsigned BA_W = ADDR_W + 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] ST_SB  = 3'b010;
    localparam logic [2:0] ST_SH  = 3'b100;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic              r_we;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic [2:0]        r_ld_mode;
    logic [2:0]        r_st_mode;

    logic              r_req_ready,  w_req_ready_nxt;
    logic              r_rsp_valid,  w_rsp_valid_nxt;
    logic [31:0]       r_rsp_rdata,  w_rsp_rdata_nxt;
    logic              r_rsp_err,    w_rsp_err_nxt;
    logic              r_mem_en,     w_mem_en_nxt;
    logic              r_mem_we,     w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]       r_mem_wdata,  w_mem_wdata_nxt;

    logic              w_accept;
    logic              w_in_byte;
    logic              w_in_half;
    logic              w_misalign;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;
    logic              w_unused_addr;

    assign w_accept      = bus.req_valid && (r_state == S_IDLE);
    assign w_unused_addr = ^bus.req_addr[31:BA_W];

    // Access width of the request currently on the bus
    always_comb begin
        w_in_byte = 1'b0;
        w_in_half = 1'b0;
        if (bus.req_we) begin
            w_in_byte = (bus.st_mode == ST_SB);
            w_in_half = (bus.st_mode == ST_SH);
        end else begin
            w_in_byte = (bus.ld_mode == LD_LB) || (bus.ld_mode == LD_LBU);
            w_in_half = (bus.ld_mode == LD_LH) || (bus.ld_mode == LD_LHU);
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (w_in_half && bus.req_addr[0]) ||
                        (!w_in_byte && !w_in_half && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane extraction/extension for loads and lane merge for partial stores
    always_comb begin
        w_lane_byte = bus.mem_rdata[{r_lane, 3'b000} +: 8];
        w_lane_half = bus.mem_rdata[{r_lane[1], 4'b0000} +: 16];
        case (r_ld_mode)
            LD_LB:   w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            LD_LBU:  w_load_data = {24'h000000, w_lane_byte};
            LD_LH:   w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            LD_LHU:  w_load_data = {16'h0000, w_lane_half};
            default: w_load_data = bus.mem_rdata;
        endcase
        w_merged = bus.mem_rdata;
        if (r_st_mode == ST_SB) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_st_mode == ST_SH) begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_misalign) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_rdata_nxt = 32'h0;
                        w_rsp_err_nxt   = 1'b1;
                    end else if (bus.req_we && !w_in_byte && !w_in_half) begin
                        w_state_nxt     = S_WR;
                        w_mem_en_nxt    = 1'b1;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_addr_nxt  = bus.req_addr[BA_W-1:2];
                        w_mem_wdata_nxt = bus.req_wdata;
                    end else begin
                        w_state_nxt     = S_RD;
                        w_mem_en_nxt    = 1'b1;
                        w_mem_addr_nxt  = bus.req_addr[BA_W-1:2];
                    end
                end
            end
            S_RD: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_we) begin
                    w_state_nxt     = S_WR;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_wdata_nxt = w_merged;
                end else begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = w_load_data;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            S_WR: begin
                w_state_nxt     = S_RESP;
                w_rsp_rdata_nxt = 32'h0;
                w_rsp_err_nxt   = 1'b0;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Latch the accepted request so the bus is free to change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_lane    <= 2'b00;
            r_wdata   <= 16'h0;
            r_ld_mode <= 3'b000;
            r_st_mode <= 3'b000;
        end else if (w_accept) begin
            r_we      <= bus.req_we;
            r_lane    <= bus.req_addr[1:0];
            r_wdata   <= bus.req_wdata[15:0];
            r_ld_mode <= bus.ld_mode;
            r_st_mode <= bus.st_mode;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural RAM, reference memory
// model and directed + randomized scenarios. Honours MEM_ALIGN_CHECK_EN.
module tb_mem_access_unit;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();
    mem_access_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int we_cycles  = 0;
    int en_cycles  = 0;
    int rsp_cycles = 0;

    // Synchronous single-port RAM, read data valid the cycle after the read
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
            else                     bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Activity counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1)    we_cycles  <= we_cycles + 1;
        if (bus.mem_en === 1'b1)    en_cycles  <= en_cycles + 1;
        if (bus.rsp_valid === 1'b1) rsp_cycles <= rsp_cycles + 1;
    end

    // Reference: expected response/latency, updates ref_mem for stores
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] ldm,
                                  input logic [2:0] stm, output logic [31:0] exp_rdata,
                                  output logic exp_err, output int exp_lat, output int exp_we);
        int size;
        int w;
        int b;
        logic misal;
        logic [31:0] v;
        w = int'(addr[ADDR_W+1:2]);
        b = int'(addr[1:0]);
        if (we) size = (stm == 3'b010) ? 1 : (stm == 3'b100) ? 2 : 4;
        else    size = (ldm == 3'd1 || ldm == 3'd2) ? 1 : (ldm == 3'd3 || ldm == 3'd4) ? 2 : 4;
        misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misal = (addr & 32'(size - 1)) != 32'h0;
`endif
        if (misal) begin
            exp_rdata = 32'h0; exp_err = 1'b1; exp_lat = 1; exp_we = 0;
            return;
        end
        if (size == 2) b = b & 2;
        if (size == 4) b = 0;
        exp_err = 1'b0;
        if (we) begin
            exp_rdata = 32'h0;
            exp_lat   = (size == 4) ? 2 : 4;
            exp_we    = 1;
            v = ref_mem[w];
            if (size == 1)      v[8*b +: 8]  = wdata[7:0];
            else if (size == 2) v[8*b +: 16] = wdata[15:0];
            else                v = wdata;
            ref_mem[w] = v;
        end else begin
            exp_lat = 3;
            exp_we  = 0;
            v = ref_mem[w] >> (8 * b);
            case (ldm)
                3'd1:    exp_rdata = 32'($signed(v[7:0]));
                3'd2:    exp_rdata = 32'(v[7:0]);
                3'd3:    exp_rdata = 32'($signed(v[15:0]));
                3'd4:    exp_rdata = 32'(v[15:0]);
                default: exp_rdata = v;
            endcase
        end
    endfunction

    // Drive one request and observe its response
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] ldm, input logic [2:0] stm,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int we_cnt, output int en_cnt,
                           output logic rsp_next, output logic [31:0] rdata_next);
        int w0;
        int e0;
        int guard;
        @(negedge clk);
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.ld_mode = ldm; bus.st_mode = stm;
        @(posedge clk);
        w0 = we_cycles; e0 = en_cycles;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_addr = $urandom;
        bus.req_wdata = $urandom; bus.ld_mode = 3'($urandom); bus.st_mode = 3'($urandom);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(negedge clk);
        rsp_next   = bus.rsp_valid;
        rdata_next = bus.rsp_rdata;
        #1;
        we_cnt = we_cycles - w0;
        en_cnt = en_cycles - e0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_tests++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_tests++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_tests++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [31:0] addrs [4] = '{32'h0C, 32'h0C, 32'h0E, 32'h0E};
        logic [2:0]  modes [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] exps  [4] = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'hFFFF_8765, 32'h0000_8765};
        logic [31:0] rd, rdn, mrd; logic er, rn, mer; int lat, wc, ec, mlat, mwe;
        ram[3] = 32'h8765_43A1; ref_mem[3] = 32'h8765_43A1;
        for (int i = 0; i < 4; i++) begin
            model(1'b0, addrs[i], 32'h0, modes[i], 3'd0, mrd, mer, mlat, mwe);
            run_req(1'b0, addrs[i], 32'h0, modes[i], 3'd0, rd, er, lat, wc, ec, rn, rdn);
            n_tests++; if (rd !== exps[i]) begin n_fail++; $display("FAIL load_data[%0d]: got %h want %h", i, rd, exps[i]); end
            n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency[%0d]: got %0d want 3", i, lat); end
            n_tests++; if (rn !== 1'b0 || rdn !== exps[i]) begin n_fail++; $display("FAIL load_pulse_hold[%0d]: valid %b data %h want 0 %h", i, rn, rdn, exps[i]); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd, rdn, mrd; logic er, rn, mer; int lat, wc, ec, mlat, mwe;
        model(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0, 3'd0, mrd, mer, mlat, mwe);
        run_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0, 3'd0, rd, er, lat, wc, ec, rn, rdn);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL sw_we_cycles: got %0d want 1", wc); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
        model(1'b0, 32'h10, 32'h0, 3'd0, 3'd0, mrd, mer, mlat, mwe);
        run_req(1'b0, 32'h10, 32'h0, 3'd0, 3'd0, rd, er, lat, wc, ec, rn, rdn);
        n_tests++; if (rd !== 32'hDEAD_BEEF || lat !== 3) begin n_fail++; $display("FAIL lw_after_sw: got %h lat %0d want deadbeef lat 3", rd, lat); end
        model(1'b1, 32'h11, 32'h55, 3'd0, 3'b010, mrd, mer, mlat, mwe);
        run_req(1'b1, 32'h11, 32'h55, 3'd0, 3'b010, rd, er, lat, wc, ec, rn, rdn);
        n_tests++; if (lat !== 4 || wc !== 1) begin n_fail++; $display("FAIL sb_timing: lat %0d we %0d want 4 1", lat, wc); end
        model(1'b1, 32'h12, 32'h1234, 3'd0, 3'b100, mrd, mer, mlat, mwe);
        run_req(1'b1, 32'h12, 32'h1234, 3'd0, 3'b100, rd, er, lat, wc, ec, rn, rdn);
        n_tests++; if (lat !== 4 || wc !== 1) begin n_fail++; $display("FAIL sh_timing: lat %0d we %0d want 4 1", lat, wc); end
        n_tests++; if (ram[4] !== 32'h1234_55EF) begin n_fail++; $display("FAIL rmw_word4: got %h want 123455ef", ram[4]); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, rdn, mrd; logic er, rn, mer; int lat, wc, ec, mlat, mwe;
        model(1'b0, 32'h0D, 32'h0, 3'd3, 3'd0, mrd, mer, mlat, mwe);
        run_req(1'b0, 32'h0D, 32'h0, 3'd3, 3'd0, rd, er, lat, wc, ec, rn, rdn);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++; if (er !== 1'b1 || lat !== 1 || ec !== 0) begin n_fail++; $display("FAIL lh_misalign: err %b lat %0d en %0d want 1 1 0", er, lat, ec); end
`else
        n_tests++; if (rd !== 32'h0000_43A1 || er !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL lh_unaligned_lane0: got %h err %b lat %0d want 000043a1 0 3", rd, er, lat); end
`endif
        model(1'b1, 32'h12, 32'hCAFE_F00D, 3'd0, 3'd0, mrd, mer, mlat, mwe);
        run_req(1'b1, 32'h12, 32'hCAFE_F00D, 3'd0, 3'd0, rd, er, lat, wc, ec, rn, rdn);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++; if (er !== 1'b1 || lat !== 1 || ec !== 0) begin n_fail++; $display("FAIL sw_misalign: err %b lat %0d en %0d want 1 1 0", er, lat, ec); end
        n_tests++; if (ram[4] !== 32'h1234_55EF) begin n_fail++; $display("FAIL sw_misalign_ram: got %h want 123455ef", ram[4]); end
`else
        n_tests++; if (er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL sw_unaligned: err %b lat %0d want 0 2", er, lat); end
        n_tests++; if (ram[4] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_unaligned_ram: got %h want cafef00d", ram[4]); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, rdn, mrd, orig; logic er, rn, mer; int lat, wc, ec, mlat, mwe, w0;
        orig = ram[8];
        @(negedge clk);
        w0 = we_cycles;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h21;
        bus.req_wdata = 32'hAA; bus.st_mode = 3'b010; bus.ld_mode = 3'd0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready); end
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold: ready %b we %b want 1 0", bus.req_ready, bus.mem_we); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_tests++; if (we_cycles - w0 !== 0 || ram[8] !== orig) begin n_fail++; $display("FAIL rst_mid_no_write: we %0d ram %h want 0 %h", we_cycles - w0, ram[8], orig); end
        model(1'b1, 32'h21, 32'hAA, 3'd0, 3'b010, mrd, mer, mlat, mwe);
        run_req(1'b1, 32'h21, 32'hAA, 3'd0, 3'b010, rd, er, lat, wc, ec, rn, rdn);
        n_tests++; if (lat !== mlat || wc !== 1 || ram[8] !== ref_mem[8]) begin n_fail++; $display("FAIL rst_mid_after: lat %0d we %0d ram %h want %0d 1 %h", lat, wc, ram[8], mlat, ref_mem[8]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, rdn, mrd, addr, wdata; logic er, rn, mer, we; logic [2:0] ldm, stm;
        int lat, wc, ec, mlat, mwe, bad;
        for (int i = 0; i < 150; i++) begin
            we    = 1'($urandom);
            addr  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            wdata = $urandom;
            ldm   = 3'($urandom_range(0, 7));
            stm   = 3'($urandom_range(0, 7));
            model(we, addr, wdata, ldm, stm, mrd, mer, mlat, mwe);
            run_req(we, addr, wdata, ldm, stm, rd, er, lat, wc, ec, rn, rdn);
            n_tests++;
            if (rd !== mrd || er !== mer || lat !== mlat || wc !== mwe || rn !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b a=%h ldm=%0d stm=%0d: got d=%h e=%b lat=%0d w=%0d want d=%h e=%b lat=%0d w=%0d",
                         i, we, addr, ldm, stm, rd, er, lat, wc, mrd, mer, mlat, mwe);
            end
        end
        bad = 0;
        for (int k = 0; k < int'(DEPTH); k++) if (ram[k] !== ref_mem[k]) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL random_ram_image: %0d words differ, want 0", bad); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [31:0] addrs [N]; logic [31:0] wdatas [N]; logic [2:0] ldms [N]; logic [2:0] stms [N];
        logic [31:0] mrd; logic mer; int mlat, mwe, lat, guard, r0, w0, exp_we;
        for (int i = 0; i < N; i++) begin
            addrs[i]  = 32'h40 + 32'($urandom_range(0, 31));
            wdatas[i] = $urandom;
            ldms[i]   = 3'($urandom_range(0, 4));
            stms[i]   = 3'($urandom_range(0, 4));
        end
        @(negedge clk);
        r0 = rsp_cycles; w0 = we_cycles; exp_we = 0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0; bus.req_addr = addrs[0]; bus.req_wdata = wdatas[0];
        bus.ld_mode = ldms[0]; bus.st_mode = stms[0];
        for (int i = 0; i < N; i++) begin
            guard = 0;
            while (bus.req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
            model(1'(i % 2), addrs[i], wdatas[i], ldms[i], stms[i], mrd, mer, mlat, mwe);
            exp_we += mwe;
            @(posedge clk);
            @(negedge clk);
            if (i + 1 < N) begin
                bus.req_we = 1'((i + 1) % 2); bus.req_addr = addrs[i+1];
                bus.req_wdata = wdatas[i+1]; bus.ld_mode = ldms[i+1]; bus.st_mode = stms[i+1];
            end else begin
                bus.req_valid = 1'b0;
            end
            lat = 1;
            while (bus.rsp_valid !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
            n_tests++;
            if (bus.rsp_rdata !== mrd || bus.rsp_err !== mer || lat !== mlat) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", i, bus.rsp_rdata, bus.rsp_err, lat, mrd, mer, mlat);
            end
            @(negedge clk);
            n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle[%0d]: valid %b ready %b want 0 1", i, bus.rsp_valid, bus.req_ready); end
        end
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        n_tests++; if (rsp_cycles - r0 !== N) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want %0d", rsp_cycles - r0, N); end
        n_tests++; if (we_cycles - w0 !== exp_we) begin n_fail++; $display("FAIL b2b_we_count: got %0d want %0d", we_cycles - w0, exp_we); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.ld_mode = 3'd0; bus.st_mode = 3'd0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            ram[k] = $urandom;
            ref_mem[k] = ram[k];
        end
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
